mult_reservation_station: RTL and testbench

//  Reservation station directly upstream of the 6-cycle multiplier unit. Buffers dispatched MUL ops

---
 rtl/mult_reservation_station.sv | 124 ++++++++++++
 tb/tb_mult_reservation_station.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_reservation_station.sv
// Reservation station feeding the multiplier: buffers MUL ops, snoops the CDB for operand
// wakeup and issues the oldest ready op as a one-cycle pulse whenever the multiplier is idle.
module mult_reservation_station #(
   parameter int DEPTH     = 4,
   parameter int XLEN      = 32,
   parameter int ROB_IDX_W = 3
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic                       flush_in,
   input  logic                       dispatch_valid_in,
   output logic                       dispatch_ready_out,
   input  logic [ROB_IDX_W-1:0]       rob_idx_in,
   input  logic                       src1_rdy_in,
   input  logic [XLEN-1:0]            src1_val_in,
   input  logic [ROB_IDX_W-1:0]       src1_tag_in,
   input  logic                       src2_rdy_in,
   input  logic [XLEN-1:0]            src2_val_in,
   input  logic [ROB_IDX_W-1:0]       src2_tag_in,
   input  logic                       cdb_valid_in,
   input  logic [ROB_IDX_W-1:0]       cdb_rob_idx_in,
   input  logic [XLEN-1:0]            cdb_data_in,
   input  logic                       mult_ready_in,
   output logic                       issue_valid_out,
   output logic [XLEN-1:0]            rval1_out,
   output logic [XLEN-1:0]            rval2_out,
   output logic [ROB_IDX_W-1:0]       rob_idx_out,
   output logic [$clog2(DEPTH):0]     count_out
);
   localparam int IW = $clog2(DEPTH);
   localparam int CW = IW + 1;

   logic [DEPTH-1:0]     busy, rdy1, rdy2;
   logic [XLEN-1:0]      val1 [DEPTH];
   logic [XLEN-1:0]      val2 [DEPTH];
   logic [ROB_IDX_W-1:0] tag1 [DEPTH];
   logic [ROB_IDX_W-1:0] tag2 [DEPTH];
   logic [ROB_IDX_W-1:0] rob  [DEPTH];
   // Age matrix: older[i][j] set when entry i was dispatched before entry j.
   logic [DEPTH-1:0]     older [DEPTH];
   logic [CW-1:0]        count;

   logic [DEPTH-1:0]     eligible, oldest;
   logic [IW-1:0]        sel_idx, free_idx;
   logic                 accept, issue;
   logic                 d_rdy1, d_rdy2;
   logic [XLEN-1:0]      d_val1, d_val2;

   assign eligible = busy & rdy1 & rdy2;

   always_comb begin
      oldest = '0;
      for (int i = 0; i < DEPTH; i++) begin
         oldest[i] = eligible[i];
         for (int j = 0; j < DEPTH; j++) begin
            if (eligible[j] && older[j][i]) oldest[i] = 1'b0;
         end
      end
   end

   always_comb begin
      sel_idx  = '0;
      free_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (oldest[i]) sel_idx = IW'(i);
      end
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!busy[i]) free_idx = IW'(i);
      end
   end

   assign dispatch_ready_out = rst_in && (count < CW'(DEPTH));
   assign accept             = dispatch_valid_in && dispatch_ready_out && !flush_in;
   assign issue              = rst_in && !flush_in && mult_ready_in && (|eligible);

   // A tag broadcast in the dispatch cycle must be captured or the wakeup is lost.
   assign d_rdy1 = src1_rdy_in || (cdb_valid_in && (cdb_rob_idx_in == src1_tag_in));
   assign d_rdy2 = src2_rdy_in || (cdb_valid_in && (cdb_rob_idx_in == src2_tag_in));
   assign d_val1 = src1_rdy_in ? src1_val_in : cdb_data_in;
   assign d_val2 = src2_rdy_in ? src2_val_in : cdb_data_in;

   assign issue_valid_out = issue;
   assign rval1_out       = issue ? val1[sel_idx] : '0;
   assign rval2_out       = issue ? val2[sel_idx] : '0;
   assign rob_idx_out     = issue ? rob[sel_idx]  : '0;
   assign count_out       = count;

   always_ff @(posedge clk_in) begin
      if (!rst_in || flush_in) begin
         busy  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) older[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (busy[i] && cdb_valid_in) begin
               if (!rdy1[i] && (tag1[i] == cdb_rob_idx_in)) begin
                  rdy1[i] <= 1'b1;
                  val1[i] <= cdb_data_in;
               end
               if (!rdy2[i] && (tag2[i] == cdb_rob_idx_in)) begin
                  rdy2[i] <= 1'b1;
                  val2[i] <= cdb_data_in;
               end
            end
         end
         if (issue) busy[sel_idx] <= 1'b0;
         if (accept) begin
            busy[free_idx] <= 1'b1;
            rdy1[free_idx] <= d_rdy1;
            rdy2[free_idx] <= d_rdy2;
            val1[free_idx] <= d_val1;
            val2[free_idx] <= d_val2;
            tag1[free_idx] <= src1_tag_in;
            tag2[free_idx] <= src2_tag_in;
            rob[free_idx]  <= rob_idx_in;
            older[free_idx] <= '0;
            for (int j = 0; j < DEPTH; j++) begin
               if (j != int'(free_idx)) older[j][free_idx] <= busy[j];
            end
         end
         count <= count + CW'(accept) - CW'(issue);
      end
   end
endmodule

// File: tb/tb_mult_reservation_station.sv
// Randomised + directed bench for mult_reservation_station: an in-order queue model predicts
// every issue; a monitor pops predicted issues and compares them with the DUT's pulses.
module tb_mult_reservation_station;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int RW    = 3;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int EW    = RW + 2 * XLEN;

  logic            clk_in = 1'b0;
  logic            rst_in, flush_in, dispatch_valid_in, dispatch_ready_out;
  logic [RW-1:0]   rob_idx_in, src1_tag_in, src2_tag_in, cdb_rob_idx_in, rob_idx_out;
  logic            src1_rdy_in, src2_rdy_in, cdb_valid_in, mult_ready_in, issue_valid_out;
  logic [XLEN-1:0] src1_val_in, src2_val_in, cdb_data_in, rval1_out, rval2_out;
  logic [CW-1:0]   count_out;

  mult_reservation_station #(.DEPTH(DEPTH), .XLEN(XLEN), .ROB_IDX_W(RW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in),
    .dispatch_valid_in(dispatch_valid_in), .dispatch_ready_out(dispatch_ready_out),
    .rob_idx_in(rob_idx_in),
    .src1_rdy_in(src1_rdy_in), .src1_val_in(src1_val_in), .src1_tag_in(src1_tag_in),
    .src2_rdy_in(src2_rdy_in), .src2_val_in(src2_val_in), .src2_tag_in(src2_tag_in),
    .cdb_valid_in(cdb_valid_in), .cdb_rob_idx_in(cdb_rob_idx_in), .cdb_data_in(cdb_data_in),
    .mult_ready_in(mult_ready_in), .issue_valid_out(issue_valid_out),
    .rval1_out(rval1_out), .rval2_out(rval2_out), .rob_idx_out(rob_idx_out),
    .count_out(count_out)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  bit issued_last = 1'b0;

  typedef struct {
    logic r1, r2;
    logic [XLEN-1:0] v1, v2;
    logic [RW-1:0] t1, t2, rob;
  } ent_t;

  ent_t m_q[$];                 // live ops, oldest first
  logic [EW-1:0] exp_q[$];      // predicted issues

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: predicts this cycle's outputs, then advances to the post-edge state
  always @(negedge clk_in) begin
    if (chk_en) begin
      int sel;
      ent_t e;
      check("count", 128'(count_out), 128'(m_q.size()));
      check("ready", 128'(dispatch_ready_out), 128'(rst_in && m_q.size() < DEPTH));
      sel = -1;
      if (rst_in && !flush_in && mult_ready_in) begin
        foreach (m_q[i]) if (sel < 0 && m_q[i].r1 && m_q[i].r2) sel = i;
      end
      if (sel >= 0) exp_q.push_back({m_q[sel].rob, m_q[sel].v1, m_q[sel].v2});
      if (!rst_in || flush_in) m_q.delete();
      else begin
        bit acc;
        acc = dispatch_valid_in && (m_q.size() < DEPTH);
        if (cdb_valid_in) begin
          foreach (m_q[i]) begin
            if (!m_q[i].r1 && m_q[i].t1 == cdb_rob_idx_in) begin m_q[i].r1 = 1; m_q[i].v1 = cdb_data_in; end
            if (!m_q[i].r2 && m_q[i].t2 == cdb_rob_idx_in) begin m_q[i].r2 = 1; m_q[i].v2 = cdb_data_in; end
          end
        end
        if (sel >= 0) m_q.delete(sel);
        if (acc) begin
          e.rob = rob_idx_in; e.t1 = src1_tag_in; e.t2 = src2_tag_in;
          e.r1 = src1_rdy_in || (cdb_valid_in && cdb_rob_idx_in == src1_tag_in);
          e.r2 = src2_rdy_in || (cdb_valid_in && cdb_rob_idx_in == src2_tag_in);
          e.v1 = src1_rdy_in ? src1_val_in : cdb_data_in;
          e.v2 = src2_rdy_in ? src2_val_in : cdb_data_in;
          m_q.push_back(e);
        end
      end
    end
  end

  // monitor / scoreboard
  always @(negedge clk_in) begin
    #2;
    if (chk_en) begin
      if (issue_valid_out) begin
        if (exp_q.size() == 0) check("unexpected_issue", 128'(1), 128'(0));
        else check("issue", 128'({rob_idx_out, rval1_out, rval2_out}), 128'(exp_q.pop_front()));
      end else if (exp_q.size() != 0) begin
        check("missing_issue", 128'(0), 128'(exp_q.pop_front()));
      end
    end
    issued_last = issue_valid_out;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    flush_in = 0; dispatch_valid_in = 0; rob_idx_in = 0;
    src1_rdy_in = 0; src1_val_in = 0; src1_tag_in = 0;
    src2_rdy_in = 0; src2_val_in = 0; src2_tag_in = 0;
    cdb_valid_in = 0; cdb_rob_idx_in = 0; cdb_data_in = 0;
  endtask

  task automatic set_disp(input logic [RW-1:0] rob, input logic r1, input logic [XLEN-1:0] v1,
                          input logic [RW-1:0] t1, input logic r2, input logic [XLEN-1:0] v2,
                          input logic [RW-1:0] t2);
    dispatch_valid_in = 1; rob_idx_in = rob;
    src1_rdy_in = r1; src1_val_in = v1; src1_tag_in = t1;
    src2_rdy_in = r2; src2_val_in = v2; src2_tag_in = t2;
  endtask

  task automatic disp(input logic [RW-1:0] rob, input logic r1, input logic [XLEN-1:0] v1,
                      input logic [RW-1:0] t1, input logic r2, input logic [XLEN-1:0] v2,
                      input logic [RW-1:0] t2);
    set_disp(rob, r1, v1, t1, r2, v2, t2);
    tick();
    dispatch_valid_in = 0;
  endtask

  task automatic cdb(input logic [RW-1:0] tag, input logic [XLEN-1:0] data);
    cdb_valid_in = 1; cdb_rob_idx_in = tag; cdb_data_in = data;
    tick();
    cdb_valid_in = 0;
  endtask

  initial begin
    idle_inputs();
    rst_in = 0; mult_ready_in = 1; dispatch_valid_in = 1;
    @(posedge clk_in); #1;
    chk_en = 1'b1;
    repeat (2) tick();
    rst_in = 1; dispatch_valid_in = 0;
    tick();

    // two ready ops, multiplier busy for a while between issues
    mult_ready_in = 0;
    disp(3'd1, 1, 32'd7, 0, 1, 32'hFFFF_FFFD, 0);
    disp(3'd2, 1, 32'd5, 0, 1, 32'd6, 0);
    mult_ready_in = 1; tick();
    mult_ready_in = 0; repeat (5) tick();
    mult_ready_in = 1; tick();
    mult_ready_in = 0; tick();

    // CDB wakeup of a pending source
    mult_ready_in = 1;
    disp(3'd3, 0, 0, 3'd5, 1, 32'd4, 0);
    tick();
    cdb(3'd5, 32'd9);
    repeat (2) tick();

    // tag on the CDB in the dispatch cycle itself, both sources
    cdb_valid_in = 1; cdb_rob_idx_in = 3'd6; cdb_data_in = 32'h10;
    disp(3'd4, 0, 0, 3'd6, 0, 0, 3'd6);
    cdb_valid_in = 0;
    repeat (2) tick();

    // fill, overflow attempt, wake only the youngest
    mult_ready_in = 0;
    for (int i = 0; i < DEPTH; i++) disp(RW'(4 + i), 0, 0, RW'(i), 1, 32'(i + 100), 0);
    disp(3'd7, 1, 32'd1, 0, 1, 32'd2, 0);
    cdb(3'd3, 32'hABCD);
    mult_ready_in = 1; tick();
    mult_ready_in = 0; tick();

    // flush with concurrent dispatch and CDB
    flush_in = 1;
    cdb_valid_in = 1; cdb_rob_idx_in = 3'd0; cdb_data_in = 32'd55;
    disp(3'd1, 1, 32'd3, 0, 1, 32'd3, 0);
    flush_in = 0; cdb_valid_in = 0; mult_ready_in = 1;
    repeat (3) tick();

    // random traffic
    for (int c = 0; c < 600; c++) begin
      idle_inputs();
      if ($urandom_range(0, 2) != 0)
        set_disp(RW'($urandom), $urandom_range(0, 2) == 0, $urandom, RW'($urandom),
                 $urandom_range(0, 2) == 0, $urandom, RW'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        cdb_valid_in = 1; cdb_rob_idx_in = RW'($urandom); cdb_data_in = $urandom;
      end
      flush_in = ($urandom_range(0, 60) == 0);
      mult_ready_in = issued_last ? 1'b0 : ($urandom_range(0, 3) != 0);
      tick();
    end

    // drain: broadcast every tag until the model is empty
    idle_inputs();
    for (int c = 0; c < 200 && m_q.size() != 0; c++) begin
      cdb_valid_in = 1; cdb_rob_idx_in = RW'(c); cdb_data_in = 32'(c * 3 + 1);
      mult_ready_in = !issued_last;
      tick();
    end
    idle_inputs(); mult_ready_in = 1;
    repeat (4) tick();
    check("drained", 128'(m_q.size()), 128'(0));
    check("exp_q_empty", 128'(exp_q.size()), 128'(0));
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
